coin_credit_accumulator: RTL and testbench



---
 rtl/coin_credit_accumulator_if.sv | 35 +++
 rtl/coin_credit_accumulator.sv | 232 +++++++++++++++++++++++
 tb/tb_coin_credit_accumulator.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_credit_accumulator_if.sv
// Coin credit accumulator bus: client/coin/session controls in, credit and
// refund reporting out. The master side drives the request fields, the slave
// side (the accumulator) drives the credit and refund fields.
interface coin_credit_accumulator_if #(
  parameter int CREDIT_W = 32
);
  logic                id_valid;
  logic [8:0]          client_id;
  logic                coin_insert;
  logic [5:0]          coin_in;
  logic [1:0]          currency_type;
  logic                vend_done;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic                credit_valid;
  logic [8:0]          session_id;
  logic                coin_accept;
  logic                coin_reject;
  logic [CREDIT_W-1:0] refund_amount;
  logic                refund_valid;

  modport master (
    output id_valid, client_id, coin_insert, coin_in, currency_type,
           vend_done, cancel,
    input  credit, credit_valid, session_id, coin_accept, coin_reject,
           refund_amount, refund_valid
  );

  modport slave (
    input  id_valid, client_id, coin_insert, coin_in, currency_type,
           vend_done, cancel,
    output credit, credit_valid, session_id, coin_accept, coin_reject,
           refund_amount, refund_valid
  );
endinterface

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: opens a client session, converts inserted coins
// into base-unit credit up to a ceiling, and closes the session on vend,
// cancel or inactivity timeout (the latter two refunding the held credit).
// Every output is a register; a coin is judged one cycle after it is
// captured, so its accept/reject pulse lands two cycles after the insert.
module coin_credit_accumulator #(
  parameter int CREDIT_W       = 32,
  parameter int MAX_CLIENTS    = 100,
  parameter int MAX_CREDIT     = 100000,
  parameter int RATE_0         = 1,
  parameter int RATE_1         = 90,
  parameter int RATE_2         = 100,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  coin_credit_accumulator_if.slave bus
);

  // Counter only has to reach TIMEOUT_CYCLES-1.
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [31:0]         MAX_CLIENTS_U = MAX_CLIENTS;
  localparam logic [CREDIT_W:0]   MAX_CREDIT_U  = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [15:0]         RATE_0_U      = 16'(RATE_0);
  localparam logic [15:0]         RATE_1_U      = 16'(RATE_1);
  localparam logic [15:0]         RATE_2_U      = 16'(RATE_2);
  localparam logic [TO_W-1:0]     TO_LAST       = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]     TO_ONE        = TO_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_CONVERT
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  // Registered outputs and datapath state.
  logic [CREDIT_W-1:0] r_credit;
  logic                r_credit_valid;
  logic [8:0]          r_session_id;
  logic                r_coin_accept;
  logic                r_coin_reject;
  logic [CREDIT_W-1:0] r_refund_amount;
  logic                r_refund_valid;
  logic [TO_W-1:0]     r_to_cnt;
  logic [5:0]          r_coin_val;
  logic [1:0]          r_coin_type;

  // Next values for the registers above.
  logic [CREDIT_W-1:0] w_credit_nxt;
  logic                w_credit_valid_nxt;
  logic [8:0]          w_session_id_nxt;
  logic                w_coin_accept_nxt;
  logic                w_coin_reject_nxt;
  logic [CREDIT_W-1:0] w_refund_amount_nxt;
  logic                w_refund_valid_nxt;
  logic [TO_W-1:0]     w_to_cnt_nxt;
  logic [5:0]          w_coin_val_nxt;
  logic [1:0]          w_coin_type_nxt;

  // Coin evaluation terms.
  logic [15:0]         w_rate;
  logic [21:0]         w_product;
  logic [CREDIT_W-1:0] w_value;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;
  logic                w_id_ok;
  logic                w_timeout;
  logic                w_abort;

  assign w_id_ok   = ({23'd0, bus.client_id} < MAX_CLIENTS_U);
  assign w_timeout = (r_to_cnt == TO_LAST);
  assign w_abort   = bus.vend_done || bus.cancel;

  // Base units per coin unit for the captured currency; type 3 never credits.
  always_comb begin
    w_rate = 16'd0;
    case (r_coin_type)
      2'd0:    w_rate = RATE_0_U;
      2'd1:    w_rate = RATE_1_U;
      2'd2:    w_rate = RATE_2_U;
      default: w_rate = 16'd0;
    endcase
  end

  assign w_product = {16'd0, r_coin_val} * {6'd0, w_rate};
  assign w_value   = CREDIT_W'(w_product);
  // One extra bit so an overflowing sum can never wrap under the ceiling.
  assign w_sum     = {1'b0, r_credit} + {1'b0, w_value};
  assign w_coin_ok = (r_coin_type != 2'd3) && (r_coin_val != 6'd0) &&
                     (w_sum <= MAX_CREDIT_U);

  // State register; reset drops any open session without refunding it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Session transitions: vend/cancel/timeout close, a coin detours via CONVERT.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.id_valid && w_id_ok) begin
          w_next_state = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_abort || w_timeout) begin
          w_next_state = S_IDLE;
        end else if (bus.coin_insert) begin
          w_next_state = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state = S_ACTIVE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Next register values: credit arithmetic, pulses, refunds and idle count.
  always_comb begin
    w_credit_nxt        = r_credit;
    w_session_id_nxt    = r_session_id;
    w_coin_accept_nxt   = 1'b0;
    w_coin_reject_nxt   = 1'b0;
    w_refund_amount_nxt = r_refund_amount;
    w_refund_valid_nxt  = 1'b0;
    w_to_cnt_nxt        = r_to_cnt;
    w_coin_val_nxt      = r_coin_val;
    w_coin_type_nxt     = r_coin_type;
    w_credit_valid_nxt  = (w_next_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        w_to_cnt_nxt = '0;
        if (bus.coin_insert) begin
          w_coin_reject_nxt = 1'b1;
        end
        if (bus.id_valid && w_id_ok) begin
          w_session_id_nxt = bus.client_id;
          w_credit_nxt     = '0;
        end
      end
      S_ACTIVE: begin
        if (bus.vend_done) begin
          w_credit_nxt = '0;
          w_to_cnt_nxt = '0;
        end else if (bus.cancel || w_timeout) begin
          w_refund_amount_nxt = r_credit;
          w_refund_valid_nxt  = 1'b1;
          w_credit_nxt        = '0;
          w_to_cnt_nxt        = '0;
        end else begin
          w_to_cnt_nxt = r_to_cnt + TO_ONE;
          if (bus.coin_insert) begin
            w_coin_val_nxt  = bus.coin_in;
            w_coin_type_nxt = bus.currency_type;
          end
        end
      end
      S_CONVERT: begin
        if (w_abort) begin
          // The pending coin goes back; the close acts on the pre-coin credit.
          w_coin_reject_nxt = 1'b1;
          w_credit_nxt      = '0;
          w_to_cnt_nxt      = '0;
          if (!bus.vend_done) begin
            w_refund_amount_nxt = r_credit;
            w_refund_valid_nxt  = 1'b1;
          end
        end else if (w_coin_ok) begin
          w_credit_nxt      = w_sum[CREDIT_W-1:0];
          w_coin_accept_nxt = 1'b1;
          w_to_cnt_nxt      = '0;
        end else begin
          w_coin_reject_nxt = 1'b1;
        end
      end
      default: begin
        w_credit_nxt = '0;
        w_to_cnt_nxt = '0;
      end
    endcase
  end

  // Output and datapath registers, cleared asynchronously with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_credit        <= '0;
      r_credit_valid  <= 1'b0;
      r_session_id    <= '0;
      r_coin_accept   <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_refund_amount <= '0;
      r_refund_valid  <= 1'b0;
      r_to_cnt        <= '0;
      r_coin_val      <= '0;
      r_coin_type     <= '0;
    end else begin
      r_credit        <= w_credit_nxt;
      r_credit_valid  <= w_credit_valid_nxt;
      r_session_id    <= w_session_id_nxt;
      r_coin_accept   <= w_coin_accept_nxt;
      r_coin_reject   <= w_coin_reject_nxt;
      r_refund_amount <= w_refund_amount_nxt;
      r_refund_valid  <= w_refund_valid_nxt;
      r_to_cnt        <= w_to_cnt_nxt;
      r_coin_val      <= w_coin_val_nxt;
      r_coin_type     <= w_coin_type_nxt;
    end
  end

  assign bus.credit        = r_credit;
  assign bus.credit_valid  = r_credit_valid;
  assign bus.session_id    = r_session_id;
  assign bus.coin_accept   = r_coin_accept;
  assign bus.coin_reject   = r_coin_reject;
  assign bus.refund_amount = r_refund_amount;
  assign bus.refund_valid  = r_refund_valid;

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Bench for coin_credit_accumulator: directed scenarios followed by random
// traffic, every cycle compared against a session-level reference model.
module tb_coin_credit_accumulator;

  localparam int CW    = 32;
  localparam int MAXC  = 200;
  localparam int TO    = 16;
  localparam int MAXCL = 100;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int compareCount  = 0;
  int mismatchCount = 0;

  // Reference model: what the outputs should show after the next edge.
  bit     mOpen;
  bit     mPending;
  int     mCoin;
  int     mType;
  longint mCredit;
  longint mSid;
  longint mRefAmt;
  bit     mRefVld;
  bit     mAcc;
  bit     mRej;
  int     mIdle;

  coin_credit_accumulator_if #(.CREDIT_W(CW)) ifc ();

  coin_credit_accumulator #(
    .CREDIT_W(CW), .MAX_CLIENTS(MAXCL), .MAX_CREDIT(MAXC),
    .RATE_0(1), .RATE_1(90), .RATE_2(100), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc.slave)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  function automatic longint rateOf(input int t);
    case (t)
      0:       return 1;
      1:       return 90;
      2:       return 100;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    compareCount++;
    if (observed != expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("credit",        ifc.credit,        mCredit);
    checkOutput("credit_valid",  ifc.credit_valid,  mOpen);
    checkOutput("session_id",    ifc.session_id,    mSid);
    checkOutput("coin_accept",   ifc.coin_accept,   mAcc);
    checkOutput("coin_reject",   ifc.coin_reject,   mRej);
    checkOutput("refund_amount", ifc.refund_amount, mRefAmt);
    checkOutput("refund_valid",  ifc.refund_valid,  mRefVld);
  endtask

  task automatic closeSession(input bit withRefund);
    if (withRefund) begin
      mRefAmt = mCredit;
      mRefVld = 1'b1;
    end
    mCredit = 0;
    mOpen   = 1'b0;
    mIdle   = 0;
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic applyStimulus(input bit idv, input int cid, input bit ci, input int cv,
                               input int ct, input bit vd, input bit cn);
    longint val;
    assert (!(mPending && ci))
      else $error("[TB] protocol violation: coin_insert while a coin is converting");
    ifc.id_valid      = idv;
    ifc.client_id     = 9'(cid);
    ifc.coin_insert   = ci;
    ifc.coin_in       = 6'(cv);
    ifc.currency_type = 2'(ct);
    ifc.vend_done     = vd;
    ifc.cancel        = cn;
    mAcc    = 1'b0;
    mRej    = 1'b0;
    mRefVld = 1'b0;
    if (!mOpen) begin
      if (ci) mRej = 1'b1;
      if (idv && cid < MAXCL) begin
        mOpen   = 1'b1;
        mSid    = cid;
        mCredit = 0;
        mIdle   = 0;
      end
    end else if (mPending) begin
      mPending = 1'b0;
      if (vd || cn) begin
        mRej = 1'b1;
        closeSession(!vd);
      end else begin
        val = longint'(mCoin) * rateOf(mType);
        if (mType != 3 && mCoin != 0 && mCredit + val <= MAXC) begin
          mCredit += val;
          mAcc  = 1'b1;
          mIdle = 0;
        end else begin
          mRej = 1'b1;
        end
      end
    end else begin
      if (vd) closeSession(1'b0);
      else if (cn || mIdle == TO - 1) closeSession(1'b1);
      else begin
        mIdle++;
        if (ci) begin
          mPending = 1'b1;
          mCoin    = cv;
          mType    = ct;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Insert a coin and let it convert; outputs then show the verdict.
  task automatic insertCoin(input int cv, input int ct);
    applyStimulus(0, 0, 1, cv, ct, 0, 0);
    idleCycle();
  endtask

  // Idle until a refund pulse, bounded; returns the number of cycles waited.
  task automatic waitRefund(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idleCycle();
      n++;
      if (ifc.refund_valid) break;
    end
  endtask

  task automatic modelReset();
    mOpen = 0; mPending = 0; mCoin = 0; mType = 0; mCredit = 0; mSid = 0;
    mRefAmt = 0; mRefVld = 0; mAcc = 0; mRej = 0; mIdle = 0;
  endtask

  // Assert reset away from the clock edge and expect outputs to clear at once.
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("async_rst_credit",       ifc.credit,       0);
    checkOutput("async_rst_credit_valid", ifc.credit_valid, 0);
    checkOutput("async_rst_refund_valid", ifc.refund_valid, 0);
    checkAll();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkAll();
  endtask

  initial begin
    int n;
    bit quiet;
    bit ci;
    int cv;
    modelReset();
    ifc.id_valid = 0; ifc.client_id = 0; ifc.coin_insert = 0; ifc.coin_in = 0;
    ifc.currency_type = 0; ifc.vend_done = 0; ifc.cancel = 0;
    repeat (2) @(negedge clk);
    checkAll();
    rst_n = 1'b1;

    // Coin with no session open is returned.
    applyStimulus(0, 0, 1, 5, 0, 0, 0);
    checkOutput("idle_coin_reject", ifc.coin_reject, 1);
    checkOutput("idle_credit_valid", ifc.credit_valid, 0);
    // Out-of-range client id opens nothing.
    applyStimulus(1, 100, 0, 0, 0, 0, 0);
    checkOutput("bad_id_no_session", ifc.credit_valid, 0);
    // Valid session plus two coins.
    applyStimulus(1, 7, 0, 0, 0, 0, 0);
    checkOutput("open_session_id", ifc.session_id, 7);
    checkOutput("open_credit_valid", ifc.credit_valid, 1);
    applyStimulus(0, 0, 1, 5, 0, 0, 0);
    checkOutput("accept_not_yet", ifc.coin_accept, 0);
    idleCycle();
    checkOutput("coin1_accept", ifc.coin_accept, 1);
    checkOutput("coin1_credit", ifc.credit, 5);
    idleCycle();
    insertCoin(2, 1);
    checkOutput("coin2_accept", ifc.coin_accept, 1);
    checkOutput("coin2_credit", ifc.credit, 185);
    // Reserved currency and zero face value.
    insertCoin(4, 3);
    checkOutput("type3_reject", ifc.coin_reject, 1);
    checkOutput("type3_credit", ifc.credit, 185);
    insertCoin(0, 2);
    checkOutput("zero_reject", ifc.coin_reject, 1);
    checkOutput("zero_credit", ifc.credit, 185);
    // Cancel refunds the held credit.
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("cancel_refund_valid", ifc.refund_valid, 1);
    checkOutput("cancel_refund_amount", ifc.refund_amount, 185);
    checkOutput("cancel_credit", ifc.credit, 0);
    checkOutput("cancel_closed", ifc.credit_valid, 0);

    // Ceiling: exactly MAX_CREDIT is accepted, one more unit is not.
    applyStimulus(1, 7, 0, 0, 0, 0, 0);
    insertCoin(2, 1);
    insertCoin(5, 0);
    insertCoin(15, 0);
    checkOutput("ceiling_accept", ifc.coin_accept, 1);
    checkOutput("ceiling_credit", ifc.credit, 200);
    insertCoin(1, 0);
    checkOutput("over_ceiling_reject", ifc.coin_reject, 1);
    checkOutput("over_ceiling_credit", ifc.credit, 200);
    // Vend and cancel together: vend wins, no refund.
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("vend_no_refund", ifc.refund_valid, 0);
    checkOutput("vend_closed", ifc.credit_valid, 0);
    checkOutput("vend_refund_held", ifc.refund_amount, 185);

    // Timeout 16 cycles after the last accept.
    applyStimulus(1, 3, 0, 0, 0, 0, 0);
    insertCoin(1, 1);
    checkOutput("to_accept", ifc.coin_accept, 1);
    waitRefund(n);
    checkOutput("timeout_distance", n, 16);
    checkOutput("timeout_refund", ifc.refund_amount, 90);
    // A coin late in the window restarts the count.
    applyStimulus(1, 4, 0, 0, 0, 0, 0);
    insertCoin(1, 1);
    repeat (14) idleCycle();
    insertCoin(1, 0);
    checkOutput("restart_accept", ifc.coin_accept, 1);
    checkOutput("restart_no_refund", ifc.refund_valid, 0);
    waitRefund(n);
    checkOutput("restart_distance", n, 16);
    checkOutput("restart_refund", ifc.refund_amount, 91);

    // Cancel while a coin is converting: coin returned, pre-coin credit refunded.
    applyStimulus(1, 9, 0, 0, 0, 0, 0);
    insertCoin(1, 2);
    applyStimulus(0, 0, 1, 50, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("race_reject", ifc.coin_reject, 1);
    checkOutput("race_no_accept", ifc.coin_accept, 0);
    checkOutput("race_refund_valid", ifc.refund_valid, 1);
    checkOutput("race_refund_amount", ifc.refund_amount, 100);

    // Reset in the middle of a session.
    applyStimulus(1, 11, 0, 0, 0, 0, 0);
    insertCoin(3, 0);
    doReset();

    // Random traffic in busy and quiet stretches.
    for (int blk = 0; blk < 50; blk++) begin
      quiet = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 64; c++) begin
        ci = !mPending && !quiet && ($urandom_range(0, 2) == 0);
        cv = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 3));
        applyStimulus($urandom_range(0, 9) == 0, int'($urandom_range(0, 130)), ci, cv,
                      int'($urandom_range(0, 3)),
                      !quiet && ($urandom_range(0, 39) == 0),
                      !quiet && ($urandom_range(0, 29) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
